// File: rtl/reg_file_2r1w_pkg.sv
// Shared types and constants for the 2-read/1-write register file.
package reg_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clear_state_e;

  localparam int unsigned NUM_READ_PORTS = 2;

  // Wide enough for any sane DATA_WIDTH; users slice the low bits.
  localparam logic [255:0] RESET_DATA = '0;

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for reg_file_2r1w: write port, two read ports, clear control/status.
interface reg_file_2r1w_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  read_enable_1;
  logic [ADDR_WIDTH-1:0] read_addr_1;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic                  read_enable_2;
  logic [ADDR_WIDTH-1:0] read_addr_2;
  logic [DATA_WIDTH-1:0] read_data_2;
  logic                  clear_req;
  logic                  clear_busy;
  logic                  clear_done;
  logic                  wr_drop;

  modport master (
    output write_enable, write_addr, write_data,
    output read_enable_1, read_addr_1, read_enable_2, read_addr_2,
    output clear_req,
    input  read_data_1, read_data_2, clear_busy, clear_done, wr_drop
  );

  modport slave (
    input  write_enable, write_addr, write_data,
    input  read_enable_1, read_addr_1, read_enable_2, read_addr_2,
    input  clear_req,
    output read_data_1, read_data_2, clear_busy, clear_done, wr_drop
  );
endinterface

// File: rtl/reg_file_2r1w_read_port.sv
// One combinational read port: enable gating, range check, zero-entry mask, write bypass.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int ZERO_REG   = 0
) (
  input  logic                             read_enable,
  input  logic [ADDR_WIDTH-1:0]            read_addr,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem,
  input  logic                             byp_valid,
  input  logic [ADDR_WIDTH-1:0]            byp_addr,
  input  logic [DATA_WIDTH-1:0]            byp_data,
  output logic [DATA_WIDTH-1:0]            read_data
);
  localparam logic [ADDR_WIDTH:0]   DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] ZERO    = RESET_DATA[DATA_WIDTH-1:0];

  logic                  in_range;
  logic                  masked;
  logic [DATA_WIDTH-1:0] stored;

  assign in_range = ({1'b0, read_addr} < DEPTH_X);
  assign masked   = (ZERO_REG != 0) && (read_addr == '0);

  always_comb begin
    stored = ZERO;
    for (int i = 0; i < DEPTH; i++)
      if (read_addr == ADDR_WIDTH'(i)) stored = mem[i];
  end

  // byp_valid already implies a legal, IDLE-state write, so matching the address is enough.
  always_comb begin
    read_data = ZERO;
    if (read_enable && in_range && !masked) begin
      if (byp_valid && (byp_addr == read_addr)) read_data = byp_data;
      else                                      read_data = stored;
    end
  end
endmodule

// File: rtl/reg_file_2r1w.sv
// DEPTH x DATA_WIDTH register file: 2 combinational reads, 1 sync write, sequenced bulk clear.
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int ZERO_REG   = 0
) (
  input logic           clk,
  input logic           reset,
  reg_file_2r1w_if.slave bus
);
  localparam logic [ADDR_WIDTH:0]   DEPTH_X  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH-1);
  localparam logic [DATA_WIDTH-1:0] ZERO     = RESET_DATA[DATA_WIDTH-1:0];

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  clear_state_e                     state, state_nxt;
  logic [ADDR_WIDTH-1:0]            idx, idx_nxt;
  logic                             busy_q, busy_nxt;
  logic                             done_q, done_nxt;
  logic                             drop_q, drop_nxt;
  logic                             wr_in_range, wr_legal, wr_commit;

  assign wr_in_range = ({1'b0, bus.write_addr} < DEPTH_X);
  assign wr_legal    = wr_in_range && !((ZERO_REG != 0) && (bus.write_addr == '0));
  assign wr_commit   = bus.write_enable && wr_legal && (state == IDLE);
  // A write to the hardwired zero entry is silently absorbed, not reported.
  assign drop_nxt    = bus.write_enable && (!wr_in_range || (state == CLEAR));

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clear_req) begin
          state_nxt = CLEAR;
          busy_nxt  = 1'b1;
        end
      end
      CLEAR: begin
        if (idx == LAST_IDX) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          idx_nxt  = idx + ADDR_WIDTH'(1);
          busy_nxt = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      drop_q <= drop_nxt;
    end
  end

  // Sweep and write never collide: writes only commit in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ZERO;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((state == CLEAR) && (idx == ADDR_WIDTH'(i)))
          mem[i] <= ZERO;
        else if (wr_commit && (bus.write_addr == ADDR_WIDTH'(i)))
          mem[i] <= bus.write_data;
      end
    end
  end

  logic [NUM_READ_PORTS-1:0]                 rd_en;
  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] rd_data;

  assign rd_en   = {bus.read_enable_2, bus.read_enable_1};
  assign rd_addr = {bus.read_addr_2, bus.read_addr_1};

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    reg_file_read_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .ZERO_REG  (ZERO_REG)
    ) u_rd (
      .read_enable(rd_en[p]),
      .read_addr  (rd_addr[p]),
      .mem        (mem),
      .byp_valid  (wr_commit),
      .byp_addr   (bus.write_addr),
      .byp_data   (bus.write_data),
      .read_data  (rd_data[p])
    );
  end

  assign bus.read_data_1 = rd_data[0];
  assign bus.read_data_2 = rd_data[1];
  assign bus.clear_busy  = busy_q;
  assign bus.clear_done  = done_q;
  assign bus.wr_drop     = drop_q;
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: a full 8-entry instance and a 6-entry zero-register instance
// driven with the same stimulus and compared every cycle against an array-based model.
module tb_reg_file_2r1w;
  logic clk;
  logic reset;

  reg_file_2r1w_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) if_a ();
  reg_file_2r1w_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) if_z ();

  reg_file_2r1w #(.DATA_WIDTH(8), .DEPTH(8), .ZERO_REG(0)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a)
  );
  reg_file_2r1w #(.DATA_WIDTH(8), .DEPTH(6), .ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset), .bus(if_z)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // stimulus shared by both instances
  bit         we, creq, re1, re2;
  int         wa, ra1, ra2;
  logic [7:0] wd;

  // model: k=0 -> 8 entries, k=1 -> 6 entries with entry 0 hardwired
  int         depth_m [2];
  bit         zreg_m  [2];
  logic [7:0] mem_m   [2][8];
  bit         clearing_m [2];
  int         sweep_m [2];
  bit         done_m  [2];
  bit         drop_m  [2];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_read(int k, bit en, int addr);
    if (!en || addr >= depth_m[k] || (zreg_m[k] && addr == 0)) return 8'h00;
    if (we && !clearing_m[k] && wa == addr) return wd;
    return mem_m[k][addr];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) mem_m[k][i] = 8'h00;
      clearing_m[k] = 0;
      sweep_m[k]    = 0;
      done_m[k]     = 0;
      drop_m[k]     = 0;
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      bit nd;
      nd = 0;
      drop_m[k] = we && (wa >= depth_m[k] || clearing_m[k]);
      if (clearing_m[k]) begin
        mem_m[k][sweep_m[k]] = 8'h00;
        if (sweep_m[k] == depth_m[k] - 1) begin
          clearing_m[k] = 0;
          sweep_m[k]    = 0;
          nd            = 1;
        end else begin
          sweep_m[k]++;
        end
      end else begin
        if (we && wa < depth_m[k] && !(zreg_m[k] && wa == 0)) mem_m[k][wa] = wd;
        if (creq) clearing_m[k] = 1;
      end
      done_m[k] = nd;
    end
  endtask

  task automatic drive();
    if_a.write_enable = we;  if_z.write_enable = we;
    if_a.write_addr = 3'(wa); if_z.write_addr = 3'(wa);
    if_a.write_data = wd;    if_z.write_data = wd;
    if_a.clear_req = creq;   if_z.clear_req = creq;
    if_a.read_enable_1 = re1; if_z.read_enable_1 = re1;
    if_a.read_addr_1 = 3'(ra1); if_z.read_addr_1 = 3'(ra1);
    if_a.read_enable_2 = re2; if_z.read_enable_2 = re2;
    if_a.read_addr_2 = 3'(ra2); if_z.read_addr_2 = 3'(ra2);
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      logic [7:0] r1, r2;
      logic       b, d, w;
      if (k == 0) begin
        r1 = if_a.read_data_1; r2 = if_a.read_data_2;
        b = if_a.clear_busy; d = if_a.clear_done; w = if_a.wr_drop;
      end else begin
        r1 = if_z.read_data_1; r2 = if_z.read_data_2;
        b = if_z.clear_busy; d = if_z.clear_done; w = if_z.wr_drop;
      end
      chk($sformatf("rd1[%0d]@%0d", k, ra1), 32'(r1), 32'(exp_read(k, re1, ra1)));
      chk($sformatf("rd2[%0d]@%0d", k, ra2), 32'(r2), 32'(exp_read(k, re2, ra2)));
      chk($sformatf("busy[%0d]", k), 32'(b), 32'(clearing_m[k]));
      chk($sformatf("done[%0d]", k), 32'(d), 32'(done_m[k]));
      chk($sformatf("drop[%0d]", k), 32'(w), 32'(drop_m[k]));
    end
  endtask

  task automatic step(input bit we_i, input int wa_i, input logic [7:0] wd_i, input bit creq_i,
                      input bit re1_i, input int ra1_i, input bit re2_i, input int ra2_i);
    @(negedge clk);
    we = we_i; wa = wa_i; wd = wd_i; creq = creq_i;
    re1 = re1_i; ra1 = ra1_i; re2 = re2_i; ra2 = ra2_i;
    drive();
    #1;
    check_outputs();
    @(posedge clk);
    model_clock();
  endtask

  // Reset may land mid-sweep; it must take effect without waiting for a clock edge.
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    we = 0; creq = 0; re1 = 1; re2 = 1; wd = 8'h00; wa = 0;
    model_reset();
    for (int a = 0; a < 8; a++) begin
      ra1 = a; ra2 = 7 - a;
      drive();
      #1;
      check_outputs();
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 8; a++) step(0, 0, 8'h00, 0, 1, a, 1, 7 - a);
  endtask

  initial begin
    depth_m[0] = 8; zreg_m[0] = 0;
    depth_m[1] = 6; zreg_m[1] = 1;
    we = 0; creq = 0; re1 = 0; re2 = 0; wa = 0; ra1 = 0; ra2 = 0; wd = 8'h00;
    reset = 1'b0;
    drive();
    apply_reset();

    // basic write/read, enable gating, bypass on both ports
    step(1, 3, 8'hA5, 0, 1, 3, 0, 0);
    step(0, 0, 8'h00, 0, 1, 3, 1, 3);
    step(0, 0, 8'h00, 0, 0, 3, 0, 3);
    step(1, 5, 8'h3C, 0, 1, 5, 1, 5);
    step(0, 0, 8'h00, 0, 1, 5, 1, 5);

    // zero entry and out-of-range writes
    step(1, 0, 8'hFF, 0, 1, 0, 1, 0);
    step(0, 0, 8'h00, 0, 1, 0, 1, 0);
    step(1, 7, 8'hEE, 0, 1, 7, 1, 6);
    step(1, 6, 8'hDD, 0, 1, 7, 1, 6);
    step(0, 0, 8'h00, 0, 1, 7, 1, 6);
    step(0, 0, 8'h00, 0, 1, 7, 1, 6);

    // fill, sweep with a dropped write and a re-pulsed request, then read everything
    for (int i = 0; i < 8; i++) step(1, i, 8'((i + 1) * 8'h11), 0, 1, i, 0, 0);
    step(0, 0, 8'h00, 1, 1, 7, 1, 0);
    for (int c = 0; c < 11; c++)
      step(c == 2, 2, 8'h55, c == 4, 1, (c % 2 == 0) ? 7 : 2, 1, 0);
    read_all();

    // sweep with clear_req held high: back-to-back sweeps separated by one IDLE cycle
    for (int i = 0; i < 8; i++) step(1, i, 8'(8'hF0 + i), 0, 1, i, 0, 0);
    for (int c = 0; c < 22; c++) step(0, 0, 8'h00, 1, 1, 7, 1, c % 8);
    step(0, 0, 8'h00, 0, 1, 7, 1, 0);

    // reset at sweep index 4
    for (int c = 0; c < 12 && clearing_m[0]; c++) step(0, 0, 8'h00, 0, 1, 7, 1, 0);
    for (int i = 0; i < 8; i++) step(1, i, 8'(8'h21 * (i + 1)), 0, 1, i, 0, 0);
    step(0, 0, 8'h00, 1, 1, 7, 1, 0);
    for (int c = 0; c < 8 && sweep_m[0] != 4; c++) step(0, 0, 8'h00, 0, 1, 7, 1, 4);
    chk("sweep_at_4", 32'(sweep_m[0]), 32'd4);
    apply_reset();
    step(1, 1, 8'h77, 0, 1, 1, 1, 1);
    step(0, 0, 8'h00, 0, 1, 1, 1, 1);

    // randomized traffic
    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 1), $urandom_range(0, 7), 8'($urandom), $urandom_range(0, 24) == 0,
           $urandom_range(0, 7) != 0, $urandom_range(0, 7),
           $urandom_range(0, 7) != 0, $urandom_range(0, 7));
    read_all();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
